// File: rtl/oumux_pkg.sv
// Shared types and constants for the output-mux control generator.
package oumux_pkg;

    localparam int unsigned STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        ACK   = 2'd2,
        DROP  = 2'd3
    } state_t;

    // Default legal targets: 8, 9, 13, 14, 15.
    localparam logic [15:0] DEF_VALID_MASK = 16'hE300;

endpackage

// File: rtl/oumux_sel_decode.sv
// Combinational select decoder: one-hot target vector plus legality flag.
module oumux_sel_decode
    import oumux_pkg::*;
#(
    parameter int unsigned             NUM_TGT    = 16,
    parameter int unsigned             SEL_W      = 4,
    parameter logic [NUM_TGT-1:0]      VALID_MASK = NUM_TGT'(DEF_VALID_MASK)
) (
    input  logic [SEL_W-1:0]   sel,
    output logic [NUM_TGT-1:0] onehot,
    output logic               legal
);

    // Out-of-range selects match no bit, so they decode to zero and are illegal.
    always_comb begin
        onehot = '0;
        for (int unsigned i = 0; i < NUM_TGT; i++) begin
            if (sel == SEL_W'(i)) begin
                onehot[i] = 1'b1;
            end
        end
    end

    assign legal = |(onehot & VALID_MASK);

endmodule

// File: rtl/oumux_ctrl_gen.sv
// Joins control token and oumux request, issues one kernel request, retires both sources.
// Optional error counter built when OUMUX_CTRL_ERR_CNT_EN is defined.
module oumux_ctrl_gen
    import oumux_pkg::*;
#(
    parameter int unsigned        NUM_TGT    = 16,
    parameter int unsigned        SEL_W      = 4,
    parameter logic [NUM_TGT-1:0] VALID_MASK = NUM_TGT'(DEF_VALID_MASK),
    parameter int unsigned        ERR_W      = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               t_c_req,
    output logic               t_c_ack,
    input  logic               t_oumux_req,
    output logic               t_oumux_ack,
    input  logic [SEL_W-1:0]   sel,
    output logic [NUM_TGT-1:0] i_req,
    input  logic [NUM_TGT-1:0] i_ack,
    output logic [SEL_W-1:0]   o_sel,
    output logic               o_sel_vld,
    output logic [ERR_W-1:0]   err_cnt,
    input  logic               err_clr
);

    state_t               state_q, state_d;
    logic [SEL_W-1:0]     sel_q;
    logic                 join_req;
    logic                 join_legal;
    logic [NUM_TGT-1:0]   join_onehot_unused;
    logic [NUM_TGT-1:0]   sel_q_onehot;
    logic                 sel_q_legal_unused;

    assign join_req = t_c_req & t_oumux_req;

    oumux_sel_decode #(
        .NUM_TGT    (NUM_TGT),
        .SEL_W      (SEL_W),
        .VALID_MASK (VALID_MASK)
    ) u_join_decode (
        .sel    (sel),
        .onehot (join_onehot_unused),
        .legal  (join_legal)
    );

    oumux_sel_decode #(
        .NUM_TGT    (NUM_TGT),
        .SEL_W      (SEL_W),
        .VALID_MASK (VALID_MASK)
    ) u_issue_decode (
        .sel    (sel_q),
        .onehot (sel_q_onehot),
        .legal  (sel_q_legal_unused)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            sel_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && join_req) begin
                sel_q <= sel;
            end
        end
    end

    // Outputs decode only state_q/sel_q, so acks never follow inputs combinationally.
    always_comb begin
        state_d     = state_q;
        i_req       = '0;
        t_c_ack     = 1'b0;
        t_oumux_ack = 1'b0;
        o_sel_vld   = 1'b0;
        case (state_q)
            IDLE: begin
                if (join_req) begin
                    state_d = join_legal ? ISSUE : DROP;
                end
            end
            ISSUE: begin
                i_req     = sel_q_onehot;
                o_sel_vld = 1'b1;
                if (|(i_ack & sel_q_onehot)) begin
                    state_d = ACK;
                end
            end
            ACK: begin
                t_c_ack     = 1'b1;
                t_oumux_ack = 1'b1;
                o_sel_vld   = 1'b1;
                state_d     = IDLE;
            end
            DROP: begin
                t_c_ack = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign o_sel = sel_q;

`ifdef OUMUX_CTRL_ERR_CNT_EN
    logic [ERR_W-1:0] err_q;

    // Clear wins over a same-cycle increment; the count saturates at all-ones.
    always_ff @(posedge clk) begin
        if (reset || err_clr) begin
            err_q <= '0;
        end else if (state_q == DROP && err_q != '1) begin
            err_q <= err_q + ERR_W'(1);
        end
    end

    assign err_cnt = err_q;
`else
    logic err_clr_unused;

    assign err_cnt        = '0;
    assign err_clr_unused = err_clr;
`endif

endmodule

// File: tb/tb_oumux_ctrl_gen.sv
// Randomized transaction-level bench for oumux_ctrl_gen (default-style and 4-target instances).
module tb_oumux_ctrl_gen;

    localparam int unsigned A_N    = 16;
    localparam int unsigned A_SW   = 4;
    localparam int unsigned A_EW   = 2;
    localparam logic [15:0] A_MASK = 16'hE300;

    localparam int unsigned B_N    = 4;
    localparam int unsigned B_SW   = 2;
    localparam int unsigned B_EW   = 8;
    localparam logic [3:0]  B_MASK = 4'b1111;

`ifdef OUMUX_CTRL_ERR_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    logic              a_t_c_req, a_t_c_ack, a_t_oumux_req, a_t_oumux_ack;
    logic [A_SW-1:0]   a_sel, a_o_sel;
    logic [A_N-1:0]    a_i_req, a_i_ack;
    logic              a_o_sel_vld, a_err_clr;
    logic [A_EW-1:0]   a_err_cnt;

    logic              b_t_c_req, b_t_c_ack, b_t_oumux_req, b_t_oumux_ack;
    logic [B_SW-1:0]   b_sel, b_o_sel;
    logic [B_N-1:0]    b_i_req, b_i_ack;
    logic              b_o_sel_vld, b_err_clr;
    logic [B_EW-1:0]   b_err_cnt;

    oumux_ctrl_gen #(
        .NUM_TGT    (A_N),
        .SEL_W      (A_SW),
        .VALID_MASK (A_MASK),
        .ERR_W      (A_EW)
    ) u_dut_a (
        .clk         (clk),
        .reset       (reset),
        .t_c_req     (a_t_c_req),
        .t_c_ack     (a_t_c_ack),
        .t_oumux_req (a_t_oumux_req),
        .t_oumux_ack (a_t_oumux_ack),
        .sel         (a_sel),
        .i_req       (a_i_req),
        .i_ack       (a_i_ack),
        .o_sel       (a_o_sel),
        .o_sel_vld   (a_o_sel_vld),
        .err_cnt     (a_err_cnt),
        .err_clr     (a_err_clr)
    );

    oumux_ctrl_gen #(
        .NUM_TGT    (B_N),
        .SEL_W      (B_SW),
        .VALID_MASK (B_MASK),
        .ERR_W      (B_EW)
    ) u_dut_b (
        .clk         (clk),
        .reset       (reset),
        .t_c_req     (b_t_c_req),
        .t_c_ack     (b_t_c_ack),
        .t_oumux_req (b_t_oumux_req),
        .t_oumux_ack (b_t_oumux_ack),
        .sel         (b_sel),
        .i_req       (b_i_req),
        .i_ack       (b_i_ack),
        .o_sel       (b_o_sel),
        .o_sel_vld   (b_o_sel_vld),
        .err_cnt     (b_err_cnt),
        .err_clr     (b_err_clr)
    );

    int          n_checks = 0;
    int          n_pass   = 0;
    int unsigned err_model = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int unsigned exp_err();
        return CNT_EN ? err_model : 0;
    endfunction

    task automatic check_idle_a(input string tag);
        chk({tag, "_a_ireq"},  64'(a_i_req), 64'd0);
        chk({tag, "_a_cack"},  64'(a_t_c_ack), 64'd0);
        chk({tag, "_a_oack"},  64'(a_t_oumux_ack), 64'd0);
        chk({tag, "_a_vld"},   64'(a_o_sel_vld), 64'd0);
        chk({tag, "_a_err"},   64'(a_err_cnt), 64'(exp_err()));
    endtask

    // One complete transaction on instance A: join at cycle 0, kernel ack sampled at cycle k.
    task automatic op_a(input int unsigned s, input int unsigned k, input bit stray, input bit clr);
        bit lg;
        lg = (s < A_N) && A_MASK[s];
        check_idle_a("pre");
        a_sel = s[A_SW-1:0];
        a_t_c_req = 1'b1;
        a_t_oumux_req = 1'b1;
        a_i_ack = '0;
        tick();
        if (lg) begin
            for (int unsigned c = 1; c <= k; c++) begin
                logic [15:0] noise;
                chk("issue_ireq", 64'(a_i_req), 64'd1 << s);
                chk("issue_vld",  64'(a_o_sel_vld), 64'd1);
                chk("issue_osel", 64'(a_o_sel), 64'(s));
                chk("issue_cack", 64'(a_t_c_ack), 64'd0);
                chk("issue_oack", 64'(a_t_oumux_ack), 64'd0);
                noise = stray ? (16'($urandom) | 16'h8100) : 16'h0000;
                noise[s] = 1'b0;
                if (c == k) noise[s] = 1'b1;
                a_i_ack = noise;
                tick();
            end
            chk("ack_cack", 64'(a_t_c_ack), 64'd1);
            chk("ack_oack", 64'(a_t_oumux_ack), 64'd1);
            chk("ack_ireq", 64'(a_i_req), 64'd0);
            chk("ack_vld",  64'(a_o_sel_vld), 64'd1);
            a_t_c_req = 1'b0;
            a_t_oumux_req = 1'b0;
            a_i_ack = '0;
            tick();
        end else begin
            chk("drop_cack", 64'(a_t_c_ack), 64'd1);
            chk("drop_oack", 64'(a_t_oumux_ack), 64'd0);
            chk("drop_ireq", 64'(a_i_req), 64'd0);
            chk("drop_vld",  64'(a_o_sel_vld), 64'd0);
            a_t_c_req = 1'b0;
            a_err_clr = clr;
            tick();
            a_err_clr = 1'b0;
            err_model = clr ? 0 : ((err_model == (1 << A_EW) - 1) ? err_model : err_model + 1);
        end
        check_idle_a("post");
    endtask

    task automatic op_b(input int unsigned s);
        chk("b_pre_ireq", 64'(b_i_req), 64'd0);
        chk("b_pre_vld",  64'(b_o_sel_vld), 64'd0);
        b_sel = s[B_SW-1:0];
        b_t_c_req = 1'b1;
        b_t_oumux_req = 1'b1;
        tick();
        chk("b_issue_ireq", 64'(b_i_req), 64'd1 << s);
        chk("b_issue_osel", 64'(b_o_sel), 64'(s));
        b_i_ack = '0;
        b_i_ack[s[B_SW-1:0]] = 1'b1;
        tick();
        chk("b_ack_cack", 64'(b_t_c_ack), 64'd1);
        chk("b_ack_oack", 64'(b_t_oumux_ack), 64'd1);
        chk("b_ack_ireq", 64'(b_i_req), 64'd0);
        b_t_c_req = 1'b0;
        b_t_oumux_req = 1'b0;
        b_i_ack = '0;
        tick();
        chk("b_err", 64'(b_err_cnt), 64'd0);
    endtask

    initial begin
        int unsigned s;
        reset = 1'b1;
        a_t_c_req = 1'b0; a_t_oumux_req = 1'b0; a_sel = '0; a_i_ack = '0; a_err_clr = 1'b0;
        b_t_c_req = 1'b0; b_t_oumux_req = 1'b0; b_sel = '0; b_i_ack = '0; b_err_clr = 1'b0;
        tick();
        tick();
        check_idle_a("reset");
        chk("reset_a_osel", 64'(a_o_sel), 64'd0);
        chk("reset_b_osel", 64'(b_o_sel), 64'd0);
        chk("reset_b_ireq", 64'(b_i_req), 64'd0);
        chk("reset_b_err",  64'(b_err_cnt), 64'd0);
        reset = 1'b0;
        tick();

        op_a(13, 3, 1'b0, 1'b0);
        op_a(2, 1, 1'b0, 1'b0);
        chk("pending_oreq_held", 64'(a_t_oumux_ack), 64'd0);
        op_a(8, 1, 1'b0, 1'b0);
        op_a(9, 3, 1'b1, 1'b0);

        for (int i = 0; i < 5; i++) op_a($urandom_range(0, 7), 1, 1'b0, 1'b0);
        chk("err_saturated", 64'(a_err_cnt), 64'(CNT_EN ? 3 : 0));
        op_a(11, 1, 1'b0, 1'b1);
        chk("err_clr_wins", 64'(a_err_cnt), 64'd0);

        // Abort an op with reset in its second ISSUE cycle, then re-present it.
        check_idle_a("pre_rst");
        a_sel = 4'd13; a_t_c_req = 1'b1; a_t_oumux_req = 1'b1;
        tick();
        chk("rst_issue1", 64'(a_i_req), 64'd1 << 13);
        tick();
        chk("rst_issue2", 64'(a_i_req), 64'd1 << 13);
        reset = 1'b1; a_t_c_req = 1'b0; a_t_oumux_req = 1'b0;
        tick();
        reset = 1'b0;
        err_model = 0;
        check_idle_a("rst_abort");
        chk("rst_osel", 64'(a_o_sel), 64'd0);
        op_a(13, 2, 1'b0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            s = $urandom_range(0, 15);
            op_a(s, $urandom_range(1, 4), 1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0));
        end

        for (int unsigned t = 0; t < B_N; t++) op_b(t);
        for (int i = 0; i < 8; i++) op_b($urandom_range(0, 3));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
